// File: rtl/store_addr_reader_pkg.sv
// Shared constants, types and address helper for the store_addr reader.
// Index width, DDR frame layout and FSM encoding live here.
package store_addr_reader_pkg;

   localparam int IDX_W      = 4;
   localparam int ADDR_W     = 28;
   localparam int NUM_FRAMES = 4;

   localparam logic [ADDR_W-1:0] BASE_ADDR    = 28'h0000000;
   localparam logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0400000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [ADDR_W-1:0] addr;
   } req_t;

   // Product is formed at full width, then truncated.
   function automatic logic [ADDR_W-1:0] frame_addr(
      input logic [IDX_W-1:0] idx
   );
      logic [ADDR_W+IDX_W-1:0] prod;
      prod = {{IDX_W{1'b0}}, FRAME_STRIDE}
           * {{ADDR_W{1'b0}}, idx};
      return BASE_ADDR + prod[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/store_addr_reader_if.sv
// FIFO read-side and request-side bundles for the store_addr reader.
// The reader is master on both.
interface store_addr_fifo_if;
   import store_addr_reader_pkg::*;

   logic             fifo_rd_en;
   logic [IDX_W-1:0] fifo_rd_data;
   logic             fifo_rd_empty;

   modport master (
      output fifo_rd_en,
      input  fifo_rd_data,
      input  fifo_rd_empty
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_rd_data,
      output fifo_rd_empty
   );
endinterface

interface store_addr_req_if;
   import store_addr_reader_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [IDX_W-1:0]  req_idx;
   logic [ADDR_W-1:0] req_addr;

   modport master (
      output req_valid,
      output req_idx,
      output req_addr,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_idx,
      input  req_addr,
      output req_ready
   );
endinterface

// File: rtl/store_addr_skid_buf.sv
// Small register FIFO holding prefetched {idx,addr} entries.
// Clear wins over push/pop in the same cycle.
module store_addr_skid_buf #(
   parameter  int DEPTH = 4,
   parameter  int W     = 32,
   localparam int PW    = $clog2(DEPTH),
   localparam int LW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          clr,
   input  logic [W-1:0]  din,
   output logic [LW-1:0] level,
   output logic [W-1:0]  head
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [LW-1:0] lvl_q, lvl_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (clr) begin
         wr_d  = '0;
         rd_d  = '0;
         lvl_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + PW'(1);
         end
         if (pop) begin
            rd_d = rd_q + PW'(1);
         end
         lvl_d = lvl_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign level = lvl_q;
   assign head  = mem_q[rd_q];

endmodule

// File: rtl/store_addr_reader.sv
// Pops frame indices from store_addr, prefetches them with their DDR
// base address and presents them on a valid/ready request port.
module store_addr_reader
   import store_addr_reader_pkg::*;
#(
   parameter  int RD_LATENCY = 1,
   parameter  int BUF_DEPTH  = 4,
   localparam int LVL_W      = $clog2(BUF_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   store_addr_fifo_if.master fifo,
   store_addr_req_if.master  req,
   output logic [LVL_W-1:0]  buf_level,
   output logic [15:0]       pop_cnt,
   output logic              idx_err
);

   state_e                state_q, state_d;
   logic [RD_LATENCY-1:0] infl_q, infl_d;
   logic [15:0]           pop_cnt_q, pop_cnt_d;
   logic                  idx_err_q, idx_err_d;

   logic [LVL_W:0] infl_cnt;
   logic [LVL_W:0] occ;
   logic           rd_en, capture, bad_idx, keep;
   logic           push, pop, clr, valid;
   req_t           din, head;

   // Credits count both buffered and in-flight entries.
   always_comb begin
      infl_cnt = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         infl_cnt = infl_cnt + (LVL_W+1)'(infl_q[i]);
      end
      occ = (LVL_W+1)'(buf_level) + infl_cnt;
   end

   always_comb begin
      rd_en = enable & ~fifo.fifo_rd_empty & ~flush & ~rst
            & (state_q == ST_RUN)
            & (occ < (LVL_W+1)'(BUF_DEPTH));
      infl_d    = RD_LATENCY'({infl_q, rd_en});
      capture   = infl_q[RD_LATENCY-1];
      bad_idx   = fifo.fifo_rd_data >= IDX_W'(NUM_FRAMES);
      keep      = capture & ~flush & (state_q == ST_RUN);
      push      = keep & ~bad_idx;
      pop       = valid & req.req_ready;
      clr       = flush & (state_q == ST_RUN);
      din.idx   = fifo.fifo_rd_data;
      din.addr  = frame_addr(fifo.fifo_rd_data);
      pop_cnt_d = pop_cnt_q + 16'(rd_en);
      idx_err_d = idx_err_q | (keep & bad_idx);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN:   if (flush) state_d = ST_FLUSH;
         ST_FLUSH: if (infl_cnt == '0) state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         infl_q    <= '0;
         pop_cnt_q <= '0;
         idx_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         infl_q    <= infl_d;
         pop_cnt_q <= pop_cnt_d;
         idx_err_q <= idx_err_d;
      end
   end

   store_addr_skid_buf #(
      .DEPTH (BUF_DEPTH),
      .W     ($bits(req_t))
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clr   (clr),
      .din   (din),
      .level (buf_level),
      .head  (head)
   );

   assign valid           = buf_level != '0;
   assign fifo.fifo_rd_en = rd_en;
   assign req.req_valid   = valid;
   assign req.req_idx     = valid ? head.idx : '0;
   assign req.req_addr    = valid ? head.addr : '0;
   assign pop_cnt         = pop_cnt_q;
   assign idx_err         = idx_err_q;

endmodule

// File: tb/tb_store_addr_reader.sv
// Directed bench for store_addr_reader with a behavioural store_addr FIFO.
// Expected values are hand-computed constants.
module tb_store_addr_reader;
   import store_addr_reader_pkg::*;

   logic        clk = 1'b0;
   logic        rst, enable, flush;
   logic [2:0]  buf_level;
   logic [15:0] pop_cnt;
   logic        idx_err;

   store_addr_fifo_if fif ();
   store_addr_req_if  rq ();

   store_addr_reader dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .flush     (flush),
      .fifo      (fif),
      .req       (rq),
      .buf_level (buf_level),
      .pop_cnt   (pop_cnt),
      .idx_err   (idx_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, pops = 0, first_pop = -1;
   int rd_viol = 0, stab_viol = 0, fl = 0, gaps = 0, guard = 0;

   logic [IDX_W-1:0]  q [$];
   bit                stream = 1'b0;
   logic [IDX_W-1:0]  stream_val = '0;
   bit                pop_now = 1'b0;
   logic [IDX_W-1:0]  got_idx [$];
   logic [ADDR_W-1:0] got_addr [$];
   int                got_cyc [$];
   logic              pv = 1'b0, pr = 1'b0;
   logic [IDX_W-1:0]  pidx = '0;
   logic [ADDR_W-1:0] paddr = '0;

   task automatic check(input string tag,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // FIFO model: one-cycle read latency
   always @(posedge clk) begin
      if (rst) fif.fifo_rd_data <= '0;
      else if (pop_now) begin
         if (q.size() != 0) fif.fifo_rd_data <= q.pop_front();
         else fif.fifo_rd_data <= stream_val;
      end
   end

   task automatic upd();
      fif.fifo_rd_empty = !stream && (q.size() == 0);
   endtask

   task automatic sample();
      pop_now = fif.fifo_rd_en;
      if (fif.fifo_rd_en && fif.fifo_rd_empty) rd_viol++;
      if (fif.fifo_rd_en) begin
         pops++;
         if (first_pop < 0) first_pop = cyc;
      end
      if (pv && !pr && rq.req_valid &&
          (rq.req_idx !== pidx || rq.req_addr !== paddr))
         stab_viol++;
      if (rq.req_valid && rq.req_ready) begin
         got_idx.push_back(rq.req_idx);
         got_addr.push_back(rq.req_addr);
         got_cyc.push_back(cyc);
      end
      pv    = rq.req_valid;
      pr    = rq.req_ready;
      pidx  = rq.req_idx;
      paddr = rq.req_addr;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         #1;
         sample();
         @(posedge clk);
         cyc++;
         #1;
         upd();
      end
   endtask

   function automatic logic [63:0] gi(input int i);
      return (i < got_idx.size()) ? 64'(got_idx[i]) : 64'hDEAD;
   endfunction

   function automatic logic [63:0] ga(input int i);
      return (i < got_addr.size()) ? 64'(got_addr[i]) : 64'hDEAD;
   endfunction

   function automatic int gc(input int i);
      return (i < got_cyc.size()) ? got_cyc[i] : -100;
   endfunction

   task automatic clr_got();
      got_idx.delete();
      got_addr.delete();
      got_cyc.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] e_addr [3];
      e_addr = '{28'h0C00000, 28'h0800000, 28'h0400000};
      rst          = 1'b1;
      enable       = 1'b0;
      flush        = 1'b0;
      rq.req_ready = 1'b0;
      upd();
      @(posedge clk);
      #1;
      run(2);
      rst = 1'b0;
      #1;
      check("rst_valid", 64'(rq.req_valid), 0);
      check("rst_idx", 64'(rq.req_idx), 0);
      check("rst_addr", 64'(rq.req_addr), 0);
      check("rst_level", 64'(buf_level), 0);
      check("rst_popcnt", 64'(pop_cnt), 0);
      check("rst_idxerr", 64'(idx_err), 0);
      check("rst_rden", 64'(fif.fifo_rd_en), 0);

      // 3,2,1 streamed straight through
      clr_got();
      q = '{4'd3, 4'd2, 4'd1};
      upd();
      enable       = 1'b1;
      rq.req_ready = 1'b1;
      first_pop    = -1;
      run(8);
      check("t1_count", 64'(got_idx.size()), 3);
      for (int i = 0; i < 3; i++) begin
         check("t1_idx", gi(i), 64'(3 - i));
         check("t1_addr", ga(i), 64'(e_addr[i]));
      end
      check("t1_latency", 64'(gc(0) - first_pop), 2);
      check("t1_b2b", 64'(gc(2) - gc(0)), 2);
      check("t1_popcnt", 64'(pop_cnt), 3);

      // backpressure: credits stop popping at 4
      clr_got();
      rq.req_ready = 1'b0;
      q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0,
            4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
      upd();
      pops      = 0;
      stab_viol = 0;
      run(10);
      #1;
      check("t2_pops", 64'(pops), 4);
      check("t2_level", 64'(buf_level), 4);
      check("t2_rden", 64'(fif.fifo_rd_en), 0);
      check("t2_head", 64'(rq.req_idx), 0);
      check("t2_stable", 64'(stab_viol), 0);
      check("t2_popcnt", 64'(pop_cnt), 7);
      rq.req_ready = 1'b1;
      run(14);
      check("t2_count", 64'(got_idx.size()), 10);
      for (int i = 0; i < 10; i++) begin
         check("t2_idx", gi(i), 64'(i % 4));
      end
      check("t2_addr3", ga(3), 64'(28'h0C00000));
      gaps = 0;
      for (int i = 1; i < 10; i++) begin
         if (gc(i) - gc(i - 1) != 1) gaps++;
      end
      check("t2_gaps", 64'(gaps), 0);

      // empty FIFO never popped
      pops = 0;
      run(20);
      check("t3_pops", 64'(pops), 0);
      check("t3_rdviol", 64'(rd_viol), 0);
      check("t3_popcnt", 64'(pop_cnt), 13);

      // out-of-range index dropped
      clr_got();
      q = '{4'd0, 4'd7, 4'd1};
      upd();
      run(8);
      check("t4_count", 64'(got_idx.size()), 2);
      check("t4_idx0", gi(0), 0);
      check("t4_idx1", gi(1), 1);
      check("t4_idxerr", 64'(idx_err), 1);

      // flush with 2 buffered and 1 in flight
      clr_got();
      rq.req_ready = 1'b0;
      q = '{4'd2, 4'd3, 4'd1, 4'd0};
      upd();
      run(3);
      check("t5_level_pre", 64'(buf_level), 2);
      flush     = 1'b1;
      fl        = cyc;
      first_pop = -1;
      run(1);
      flush        = 1'b0;
      rq.req_ready = 1'b1;
      #1;
      check("t5_valid", 64'(rq.req_valid), 0);
      check("t5_level", 64'(buf_level), 0);
      run(6);
      check("t5_resume", 64'(first_pop - fl), 2);
      check("t5_count", 64'(got_idx.size()), 1);
      check("t5_next", gi(0), 0);
      check("t5_idxerr", 64'(idx_err), 1);

      // reset mid-stream
      stream     = 1'b1;
      stream_val = 4'd2;
      upd();
      run(6);
      rst = 1'b1;
      run(1);
      rst    = 1'b0;
      stream = 1'b0;
      upd();
      #1;
      check("t6_valid", 64'(rq.req_valid), 0);
      check("t6_idx", 64'(rq.req_idx), 0);
      check("t6_addr", 64'(rq.req_addr), 0);
      check("t6_level", 64'(buf_level), 0);
      check("t6_popcnt", 64'(pop_cnt), 0);
      check("t6_idxerr", 64'(idx_err), 0);
      check("t6_rden", 64'(fif.fifo_rd_en), 0);
      clr_got();
      run(5);
      check("t6_stale", 64'(got_idx.size()), 0);

      // pop counter wrap
      stream     = 1'b1;
      stream_val = 4'd1;
      upd();
      pops  = 0;
      guard = 0;
      while (pops < 65537 && guard < 70000) begin
         run(1);
         guard++;
      end
      enable = 1'b0;
      clr_got();
      check("wrap_pops", 64'(pops), 65537);
      run(4);
      check("wrap_popcnt", 64'(pop_cnt), 1);
      check("wrap_idxerr", 64'(idx_err), 0);
      check("rdviol_all", 64'(rd_viol), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
